xc_mem_txn_sequencer: RTL and testbench

Sequences the up-to-four memory transactions of one coprocessor gather/scatter/load/store instruction onto the coprocessor's single memory bus. It accepts one instruction request from the execute stage and issues transactions 0..N-1 in index order, one outstanding at a time. It collects read data and error status per transaction and returns a single response to execute. Its memory-side activity per transaction is what the formal environment observes on memory transaction slots 0..3.

---
 rtl/xc_mem_txn_sequencer.sv | 158 +++++++++++++++
 tb/tb_xc_mem_txn_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_mem_txn_sequencer.sv
// xc_mem_txn_sequencer
// Issues the up-to-four memory transactions of one coprocessor gather/scatter/
// load/store instruction on a single memory bus, one outstanding at a time,
// and returns one collected response to the execute stage.
//
// Optional build macro: XC_MEM_SEQ_ABORT_ON_ERROR_EN
//   defined   -> an error on transaction k ends the instruction after k.
//   undefined -> every transaction is issued; errors are only accumulated.
//
// Handshakes: the request is taken on a cycle where req_valid && req_ready;
// the response is held (rsp_valid=1) until a cycle where rsp_ack=1; a bus
// transaction is accepted on a cycle where mem_cen && !mem_stall, and its
// mem_rdata/mem_error are valid in the following cycle.
//
// dbg_state exposes the FSM encoding: 0=IDLE 1=ISSUE 2=WAIT 3=RESP.
module xc_mem_txn_sequencer #(
  parameter int NTXN = 4
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wen,
  input  logic [2:0]           req_count,
  input  logic [32*NTXN-1:0]   req_addr,
  input  logic [32*NTXN-1:0]   req_wdata,
  input  logic [4*NTXN-1:0]    req_ben,
  output logic                 rsp_valid,
  input  logic                 rsp_ack,
  output logic [32*NTXN-1:0]   rsp_rdata,
  output logic                 rsp_error,
  output logic [NTXN-1:0]      rsp_done,
  output logic                 mem_cen,
  output logic                 mem_wen,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_ben,
  input  logic                 mem_stall,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_error,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q;
  logic [2:0]           cnt_q;
  logic                 wen_q;
  logic [32*NTXN-1:0]   addr_q;
  logic [32*NTXN-1:0]   wdata_q;
  logic [4*NTXN-1:0]    ben_q;
  logic [32*NTXN-1:0]   rdata_q;
  logic [NTXN-1:0]      done_q;
  logic                 error_q;

  logic [2:0]           eff_count;
  logic                 last_txn;
  logic                 abort_now;

  // Counts above the lane count saturate to the lane count.
  assign eff_count = (req_count > 3'(NTXN)) ? 3'(NTXN) : req_count;
  assign last_txn  = ({1'b0, idx_q} == (cnt_q - 3'd1));

`ifdef XC_MEM_SEQ_ABORT_ON_ERROR_EN
  assign abort_now = mem_error;
`else
  assign abort_now = 1'b0;
`endif

  // State register; reset drops straight to IDLE, which also kills mem_cen.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = (eff_count == 3'd0) ? S_RESP : S_ISSUE;
      S_ISSUE: if (!mem_stall) state_d = S_WAIT;
      S_WAIT:  state_d = (last_txn || abort_now) ? S_RESP : S_ISSUE;
      S_RESP:  if (rsp_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, lane index and response collection.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      idx_q   <= 2'd0;
      cnt_q   <= 3'd0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ben_q   <= '0;
      rdata_q <= '0;
      done_q  <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            rdata_q <= '0;
            done_q  <= '0;
            error_q <= 1'b0;
            idx_q   <= 2'd0;
            // A zero-count request carries nothing worth keeping.
            if (eff_count != 3'd0) begin
              cnt_q   <= eff_count;
              wen_q   <= req_wen;
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              ben_q   <= req_ben;
            end
          end
        end
        S_WAIT: begin
          done_q[idx_q] <= 1'b1;
          error_q       <= error_q | mem_error;
          if (!wen_q) rdata_q[{idx_q, 5'd0} +: 32] <= mem_rdata;
          if (!(last_txn || abort_now)) idx_q <= idx_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Bus fields come from the current lane only while a request is driven.
  always_comb begin
    mem_cen   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_ben   = '0;
    if (state_q == S_ISSUE) begin
      mem_cen   = 1'b1;
      mem_wen   = wen_q;
      mem_addr  = addr_q[{idx_q, 5'd0} +: 32];
      mem_wdata = wdata_q[{idx_q, 5'd0} +: 32];
      mem_ben   = ben_q[{idx_q, 2'd0} +: 4];
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_done  = done_q;
  assign rsp_error = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_xc_mem_txn_sequencer.sv
// Testbench for xc_mem_txn_sequencer: directed and random instructions, a
// memory responder driven from an expected-transaction queue, and a response
// checker fed by an expected-response queue.
module tb_xc_mem_txn_sequencer;

  localparam int WR = 136; // {rdata[127:0], error, done[3:0], issued[2:0]}
  localparam int WT = 102; // {wen, addr[31:0], wdata[31:0], ben[3:0], rdata[31:0], err}

  logic         g_clk = 1'b0;
  logic         g_resetn;
  logic         req_valid, req_ready, req_wen;
  logic [2:0]   req_count;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_ben;
  logic         rsp_valid, rsp_ack;
  logic [127:0] rsp_rdata;
  logic         rsp_error;
  logic [3:0]   rsp_done;
  logic         mem_cen, mem_wen;
  logic [31:0]  mem_addr, mem_wdata;
  logic [3:0]   mem_ben;
  logic         mem_stall;
  logic [31:0]  mem_rdata;
  logic         mem_error;
  logic [1:0]   dbg_state;

  xc_mem_txn_sequencer #(.NTXN(4)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_count(req_count), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ben(req_ben),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_done(rsp_done),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ben(mem_ben), .mem_stall(mem_stall),
    .mem_rdata(mem_rdata), .mem_error(mem_error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 g_clk = ~g_clk;

  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [WR-1:0] exp_q[$];
  logic [WT-1:0] bus_q[$];
  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int stall_total = 0;
  int force_stall = 0;
  bit rand_stall = 0;
  int acc_cyc = 0;
  int stall_snap = 0;
  logic [132:0] last_rsp = '0; // {rdata, error, done}

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the bus must see and what execute must get back.
  task automatic model_push(input logic wen, input logic [2:0] cnt,
                            input logic [127:0] a, input logic [127:0] wd,
                            input logic [15:0] be, input logic [127:0] rd,
                            input logic [3:0] er);
    int n;
    int issued;
    logic [127:0] r;
    logic e;
    logic [3:0] d;
    n = (cnt > 3'd4) ? 4 : int'(cnt);
    issued = 0;
    r = '0;
    e = 1'b0;
    d = '0;
    for (int i = 0; i < n; i++) begin
      bus_q.push_back({wen, a[32*i +: 32], wd[32*i +: 32], be[4*i +: 4], rd[32*i +: 32], er[i]});
      issued++;
      d[i] = 1'b1;
      e = e | er[i];
      if (!wen) r[32*i +: 32] = rd[32*i +: 32];
`ifdef XC_MEM_SEQ_ABORT_ON_ERROR_EN
      if (er[i]) break;
`endif
    end
    exp_q.push_back({r, e, d, 3'(issued)});
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_rsp_rdata", rsp_rdata, 128'd0);
    chk("rst_rsp_done", 128'(rsp_done), 128'd0);
    chk("rst_rsp_error", 128'(rsp_error), 128'd0);
    chk("rst_mem_cen", 128'(mem_cen), 128'd0);
    chk("rst_mem_fields", {59'd0, mem_wen, mem_addr, mem_wdata, mem_ben}, 128'd0);
    chk("rst_state", 128'(dbg_state), 128'd0);
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic wen, input logic [2:0] cnt,
                        input logic [127:0] a, input logic [127:0] wd,
                        input logic [15:0] be, input logic [127:0] rd,
                        input logic [3:0] er, input int stalls);
    int t;
    t = 0;
    while (!(req_ready && exp_q.size() == 0) && t < 300) begin
      @(negedge g_clk); #1;
      t++;
    end
    if (t >= 300) begin
      chk("req_ready_timeout", 128'(req_ready), 128'd1);
      return;
    end
    // Response outputs persist until the next request is taken.
    chk("hold_rsp", {last_rsp[132:0]}, {rsp_rdata, rsp_error, rsp_done});
    model_push(wen, cnt, a, wd, be, rd, er);
    force_stall = stalls;
    acc_cyc     = cyc;
    stall_snap  = stall_total;
    req_wen   = wen;
    req_count = cnt;
    req_addr  = a;
    req_wdata = wd;
    req_ben   = be;
    req_valid = 1'b1;
    @(negedge g_clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom, $urandom, $urandom};
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && bus_q.size() == 0 && req_ready) && t < 500) begin
      @(negedge g_clk); #1;
      t++;
    end
    chk("drain_timeout", 128'(t < 500), 128'd1);
  endtask

  // ---------------- memory responder / bus monitor ----------------
  logic         pend_v = 1'b0;
  logic [31:0]  pend_rd;
  logic         pend_err;

  always @(negedge g_clk) begin
    logic [WT-1:0] t;
    if (!g_resetn) begin
      mem_stall = 1'b0;
      pend_v    = 1'b0;
    end else begin
      if (pend_v) begin
        mem_rdata = pend_rd;
        mem_error = pend_err;
        pend_v    = 1'b0;
      end else begin
        mem_rdata = $urandom;
        mem_error = 1'($urandom_range(0, 1));
      end
      if (mem_cen) begin
        if (force_stall > 0) begin
          mem_stall = 1'b1;
          force_stall--;
        end else begin
          mem_stall = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (bus_q.size() == 0) begin
          chk("unexpected_txn", 128'(mem_cen), 128'd0);
        end else begin
          t = bus_q[0];
          chk("mem_wen", 128'(mem_wen), 128'(t[101]));
          chk("mem_addr", 128'(mem_addr), 128'(t[100:69]));
          chk("mem_wdata", 128'(mem_wdata), 128'(t[68:37]));
          chk("mem_ben", 128'(mem_ben), 128'(t[36:33]));
          if (!mem_stall) begin
            void'(bus_q.pop_front());
            pend_v   = 1'b1;
            pend_rd  = t[32:1];
            pend_err = t[0];
            acc_cnt++;
          end else begin
            stall_total++;
          end
        end
      end else begin
        mem_stall = 1'($urandom_range(0, 1));
        chk("idle_bus_zero", {59'd0, mem_wen, mem_addr, mem_wdata, mem_ben}, 128'd0);
      end
    end
  end

  // ---------------- response monitor ----------------
  bit seen = 0;
  int ack_wait = 0;

  always @(negedge g_clk) begin
    logic [WR-1:0] e;
    int lat;
    if (!g_resetn) begin
      rsp_ack = 1'b0;
      seen    = 0;
    end else if (rsp_valid) begin
      if (!seen) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 128'(rsp_valid), 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e[135:8]);
          chk("rsp_error", 128'(rsp_error), 128'(e[7]));
          chk("rsp_done", 128'(rsp_done), 128'(e[6:3]));
          lat = 1 + 2 * int'(e[2:0]) + (stall_total - stall_snap);
          chk("rsp_latency", 128'(cyc - acc_cyc), 128'(lat));
          last_rsp = e[135:3];
        end
        ack_wait = $urandom_range(0, 2);
      end
      if (ack_wait == 0) rsp_ack = 1'b1;
      else begin
        ack_wait--;
        rsp_ack = 1'b0;
      end
    end else begin
      rsp_ack = 1'b0;
      seen    = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int base;
    logic [127:0] ra, rw, rr;
    g_resetn  = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_count = 3'd0;
    req_addr  = '0;
    req_wdata = '0;
    req_ben   = '0;
    rsp_ack   = 1'b0;
    mem_stall = 1'b0;
    mem_rdata = '0;
    mem_error = 1'b0;
    repeat (3) @(negedge g_clk);
    #1;
    check_reset_vals();
    g_resetn = 1'b1;
    @(negedge g_clk); #1;

    // Four-lane load, no stall.
    do_req(1'b0, 3'd4, {32'h10C, 32'h108, 32'h104, 32'h100}, '0, 16'hFFFF,
           {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'h0, 0);
    // Two-lane store with three stall cycles on the first transaction.
    do_req(1'b1, 3'd2, {64'd0, 32'h204, 32'h200}, {64'd0, 32'h12345678, 32'hDEADBEEF},
           16'h003F, {$urandom, $urandom, $urandom, $urandom}, 4'h0, 3);
    // Zero count, then a saturating count of seven.
    do_req(1'b0, 3'd0, '0, '0, '0, '0, 4'h0, 0);
    do_req(1'b0, 3'd7, {32'h40C, 32'h408, 32'h404, 32'h400}, '0, 16'hF0F0,
           {32'h11, 32'h22, 32'h33, 32'h44}, 4'h0, 0);
    // Error on transaction 1 of 4.
    do_req(1'b0, 3'd4, {32'h50C, 32'h508, 32'h504, 32'h500}, '0, 16'hFFFF,
           {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b0010, 0);
    drain();

    // Random instructions with random stalls and acknowledge delays.
    rand_stall = 1;
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rw = {$urandom, $urandom, $urandom, $urandom};
      rr = {$urandom, $urandom, $urandom, $urandom};
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rw,
             16'($urandom), rr,
             {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0}, 0);
    end
    drain();
    rand_stall = 0;

    // Reset while waiting on transaction 2 of a four-lane load.
    base = acc_cnt;
    do_req(1'b0, 3'd4, {32'h60C, 32'h608, 32'h604, 32'h600}, '0, 16'hFFFF,
           {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4'h0, 0);
    t = 0;
    while (acc_cnt < base + 3 && t < 100) begin
      @(negedge g_clk); #1;
      t++;
    end
    chk("reach_txn2", 128'(acc_cnt >= base + 3), 128'd1);
    @(negedge g_clk); #1;
    chk("in_wait_before_reset", 128'(dbg_state), 128'd2);
    g_resetn = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    bus_q.delete();
    last_rsp = '0;
    repeat (2) @(negedge g_clk);
    #1;
    g_resetn = 1'b1;
    @(negedge g_clk); #1;
    do_req(1'b0, 3'd1, {96'd0, 32'h700}, '0, 16'h000F,
           {32'hEE, 32'hEE, 32'hEE, 32'hD0}, 4'h0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
